// File: rtl/cnn_pkg.sv
// Shared defaults for the systolic-array input buffering.
// Channel count, word width, FIFO geometry and slice helpers.
package cnn_pkg;

    localparam int CNN_DATA_SIZE  = 8;
    localparam int CNN_ARRAY_SIZE = 9;
    localparam int CNN_FIFO_DEPTH = 256;
    localparam int CNN_LOG_DEPTH  = 8;
    localparam int CNN_AF_THRESH  = 248;

    function automatic int cnt_w(input int log_depth);
        return log_depth + 1;
    endfunction

    localparam int CNN_CNT_W = cnt_w(CNN_LOG_DEPTH);

endpackage

// File: rtl/fifo_channel.sv
// Single-clock FIFO for one array row.
// Registered count/flags and a one-cycle registered read port.
module fifo_channel
    import cnn_pkg::*;
#(
    parameter int DATA_SIZE  = CNN_DATA_SIZE,
    parameter int FIFO_DEPTH = CNN_FIFO_DEPTH,
    parameter int LOG_DEPTH  = CNN_LOG_DEPTH,
    parameter int AF_THRESH  = CNN_AF_THRESH
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 i_wr_en,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic                 i_rd_en,
    output logic [DATA_SIZE-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic [LOG_DEPTH:0]   o_count
);

    localparam int CW = LOG_DEPTH + 1;
    localparam logic [LOG_DEPTH:0] L_FULL = CW'(FIFO_DEPTH);
    localparam logic [LOG_DEPTH:0] L_AF   = CW'(AF_THRESH);

    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [LOG_DEPTH-1:0] r_wptr;
    logic [LOG_DEPTH-1:0] r_rptr;
    logic [LOG_DEPTH:0]   r_count;
    logic [LOG_DEPTH:0]   w_cnt_nxt;
    logic [DATA_SIZE-1:0] r_rdata;
    logic                 r_rvalid;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_af;
    logic                 w_wr;
    logic                 w_rd;

    // Read qualifies on the registered flag, so a fresh word waits a cycle.
    assign w_wr = i_wr_en & ~r_full;
    assign w_rd = i_rd_en & ~r_empty;

    always_comb begin
        w_cnt_nxt = r_count;
        unique case (1'b1)
            (w_wr && !w_rd): w_cnt_nxt = r_count + 1'b1;
            (w_rd && !w_wr): w_cnt_nxt = r_count - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr   <= r_rptr + 1'b1;
                r_rdata  <= r_mem[r_rptr];
                r_rvalid <= 1'b1;
            end else begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == L_FULL);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= L_AF);
        end
    end

    assign o_rd_data     = r_rdata;
    assign o_rd_valid    = r_rvalid;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_almost_full = r_af;
    assign o_count       = r_count;

endmodule

// File: rtl/fifo_bank.sv
// Bank of row FIFOs feeding a systolic array.
// Optional diagonal skew: row i is delayed i extra cycles.
module fifo_bank
    import cnn_pkg::*;
#(
    parameter int DATA_SIZE  = CNN_DATA_SIZE,
    parameter int FIFO_DEPTH = CNN_FIFO_DEPTH,
    parameter int LOG_DEPTH  = CNN_LOG_DEPTH,
    parameter int ARRAY_SIZE = CNN_ARRAY_SIZE,
    parameter int AF_THRESH  = CNN_AF_THRESH
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic [ARRAY_SIZE-1:0]               w_en,
    input  logic [ARRAY_SIZE*DATA_SIZE-1:0]     dataIn,
    input  logic                                r_en,
    input  logic                                skew_en,
    output logic [ARRAY_SIZE*DATA_SIZE-1:0]     dataOut,
    output logic [ARRAY_SIZE-1:0]               valid,
    output logic [ARRAY_SIZE-1:0]               full,
    output logic [ARRAY_SIZE-1:0]               empty,
    output logic [ARRAY_SIZE-1:0]               almost_full,
    output logic [ARRAY_SIZE*(LOG_DEPTH+1)-1:0] count
);

    localparam int CW = cnt_w(LOG_DEPTH);

    logic r_skew;

    // Mode switch lands one cycle later; the idle path's words are dropped.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_skew <= 1'b0;
        end else begin
            r_skew <= skew_en;
        end
    end

    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_ch
        logic                 w_cv;
        logic [DATA_SIZE-1:0] w_cd;
        logic                 w_sv;
        logic [DATA_SIZE-1:0] w_sd;

        fifo_channel #(
            .DATA_SIZE (DATA_SIZE),
            .FIFO_DEPTH(FIFO_DEPTH),
            .LOG_DEPTH (LOG_DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_ch (
            .clk          (clk),
            .clear        (clear),
            .i_wr_en      (w_en[gi]),
            .i_wr_data    (dataIn[gi*DATA_SIZE +: DATA_SIZE]),
            .i_rd_en      (r_en),
            .o_rd_data    (w_cd),
            .o_rd_valid   (w_cv),
            .o_full       (full[gi]),
            .o_empty      (empty[gi]),
            .o_almost_full(almost_full[gi]),
            .o_count      (count[gi*CW +: CW])
        );

        if (gi == 0) begin : g_nodly
            assign w_sv = w_cv;
            assign w_sd = w_cd;
        end else begin : g_dly
            logic [DATA_SIZE:0] r_line [gi];

            always_ff @(posedge clk or posedge clear) begin
                if (clear) begin
                    for (int k = 0; k < gi; k++) begin
                        r_line[k] <= '0;
                    end
                end else begin
                    r_line[0] <= {w_cv, w_cd};
                    for (int k = 1; k < gi; k++) begin
                        r_line[k] <= r_line[k-1];
                    end
                end
            end

            assign w_sv = r_line[gi-1][DATA_SIZE];
            assign w_sd = r_line[gi-1][DATA_SIZE-1:0];
        end

        assign valid[gi] = r_skew ? w_sv : w_cv;
        assign dataOut[gi*DATA_SIZE +: DATA_SIZE] =
            valid[gi] ? (r_skew ? w_sd : w_cd) : '0;
    end

endmodule

// File: tb/tb_fifo_bank.sv
// Randomized scoreboard bench for fifo_bank.
// Queue-based reference model; monitor checks on falling edges.
module tb_fifo_bank;
    import cnn_pkg::*;

    localparam int DS    = 8;
    localparam int AS    = 9;
    localparam int DEPTH = 256;
    localparam int LD    = 8;
    localparam int AF    = 248;
    localparam int CW    = CNN_CNT_W;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic [AS-1:0] w_en = '0;
    logic [AS*DS-1:0] dataIn = '0;
    logic          r_en = 1'b0;
    logic          skew_en = 1'b0;
    logic [AS*DS-1:0] dataOut;
    logic [AS-1:0] valid;
    logic [AS-1:0] full;
    logic [AS-1:0] empty;
    logic [AS-1:0] almost_full;
    logic [AS*CW-1:0] count;

    fifo_bank #(
        .DATA_SIZE (DS),
        .FIFO_DEPTH(DEPTH),
        .LOG_DEPTH (LD),
        .ARRAY_SIZE(AS),
        .AF_THRESH (AF)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .w_en       (w_en),
        .dataIn     (dataIn),
        .r_en       (r_en),
        .skew_en    (skew_en),
        .dataOut    (dataOut),
        .valid      (valid),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [DS-1:0] d;
    } exp_t;

    logic [DS-1:0] mdl [AS][$];
    exp_t          exq [AS][$];
    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;

    task automatic chk(input string nm, input int ch,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ch%0d: got 0x%0h want 0x%0h cycle %0d",
                      nm, ch, act, exp, cyc);
    endtask

    task automatic step();
        int sz [AS];
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!clear) begin
            for (int i = 0; i < AS; i++) sz[i] = mdl[i].size();
            for (int i = 0; i < AS; i++) begin
                if (r_en && sz[i] > 0) begin
                    e.d   = mdl[i].pop_front();
                    e.due = cyc + (skew_en ? i : 0);
                    exq[i].push_back(e);
                end
                if (w_en[i] && sz[i] < DEPTH)
                    mdl[i].push_back(dataIn[i*DS +: DS]);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        w_en = '0;
        r_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic set_skew(input logic v);
        idle(AS + 1);
        skew_en = v;
        step();
    endtask

    task automatic wr(input int ch, input logic [DS-1:0] d, input logic rd);
        w_en = '0;
        w_en[ch] = 1'b1;
        dataIn[ch*DS +: DS] = d;
        r_en = rd;
        step();
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < AS; i++) begin
            logic v;
            logic [DS-1:0] d;
            exp_t e;
            int sz;
            v = valid[i];
            d = dataOut[i*DS +: DS];
            if (v) begin
                if (exq[i].size() == 0) begin
                    chk("spurious_valid", i, 32'(v), 32'd0);
                end else begin
                    e = exq[i].pop_front();
                    chk("data", i, 32'(d), 32'(e.d));
                    chk("latency", i, cyc, e.due);
                end
            end else begin
                chk("zero_pad", i, 32'(d), 32'd0);
                if (exq[i].size() > 0 && exq[i][0].due <= cyc) begin
                    chk("missing_valid", i, 32'(v), 32'd1);
                    e = exq[i].pop_front();
                end
            end
            sz = mdl[i].size();
            chk("count", i, 32'(count[i*CW +: CW]), sz);
            chk("full", i, 32'(full[i]), 32'(sz == DEPTH));
            chk("empty", i, 32'(empty[i]), 32'(sz == 0));
            chk("almost_full", i, 32'(almost_full[i]), 32'(sz >= AF));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_valid", 0, 32'(valid), 32'd0);
        chk("rst_empty", 0, 32'(empty), 32'({AS{1'b1}}));
        chk("rst_full", 0, 32'(full), 32'd0);
        for (int i = 0; i < AS; i++)
            chk("rst_data", i, 32'(dataOut[i*DS +: DS]), 32'd0);
        clear = 1'b0;

        wr(0, 8'h01, 1'b0);
        w_en = '0;
        r_en = 1'b1;
        step();
        idle(3);

        for (int k = 0; k < 257; k++)
            wr(3, (k < 256) ? 8'(k) : 8'h55, 1'b0);
        w_en = '0;
        chk("full3", 3, 32'(full[3]), 32'd1);
        chk("cnt3", 3, 32'(count[3*CW +: CW]), 32'd256);
        r_en = 1'b1;
        repeat (260) step();
        idle(2);

        set_skew(1'b1);
        w_en = '1;
        for (int i = 0; i < AS; i++) dataIn[i*DS +: DS] = 8'(8'h10 + i);
        step();
        w_en = '0;
        r_en = 1'b1;
        step();
        idle(AS + 2);

        set_skew(1'b0);
        for (int k = 0; k < 10; k++) wr(5, 8'($urandom), 1'b0);
        for (int k = 0; k < 300; k++) wr(5, 8'($urandom), 1'b1);
        w_en = '0;
        r_en = 1'b0;
        chk("cnt5", 5, 32'(count[5*CW +: CW]), 32'd10);
        r_en = 1'b1;
        repeat (12) step();

        for (int seg = 0; seg < 4; seg++) begin
            int wp;
            int rp;
            set_skew(1'($urandom_range(0, 1)));
            wp = (seg == 1) ? 90 : 50;
            rp = (seg == 1) ? 20 : 55;
            repeat (400) begin
                for (int i = 0; i < AS; i++) begin
                    w_en[i] = ($urandom_range(0, 99) < wp);
                    dataIn[i*DS +: DS] = 8'($urandom);
                end
                r_en = ($urandom_range(0, 99) < rp);
                step();
            end
        end

        set_skew(1'b1);
        repeat (20) begin
            for (int i = 0; i < AS; i++) begin
                w_en[i] = 1'b1;
                dataIn[i*DS +: DS] = 8'($urandom);
            end
            r_en = 1'b1;
            step();
        end
        #1;
        clear = 1'b1;
        #1;
        chk("clr_valid", 0, 32'(valid), 32'd0);
        chk("clr_empty", 0, 32'(empty), 32'({AS{1'b1}}));
        chk("clr_full", 0, 32'(full), 32'd0);
        chk("clr_af", 0, 32'(almost_full), 32'd0);
        for (int i = 0; i < AS; i++) begin
            chk("clr_data", i, 32'(dataOut[i*DS +: DS]), 32'd0);
            chk("clr_count", i, 32'(count[i*CW +: CW]), 32'd0);
            mdl[i].delete();
            exq[i].delete();
        end
        step();
        step();
        clear = 1'b0;
        wr(0, 8'hA5, 1'b0);
        w_en = '0;
        r_en = 1'b1;
        step();
        idle(AS + 2);

        for (int i = 0; i < AS; i++)
            chk("leftover", i, exq[i].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fifo_bank.md
FIFO_BANK -- requirements
Module: fifo_bank

Interface
REQ-001 Parameter DATA_SIZE, default 8, width of one data word.
REQ-002 Parameter FIFO_DEPTH, default 256, words per channel; SHALL be a power of two.
REQ-003 Parameter LOG_DEPTH, default 8, log2(FIFO_DEPTH).
REQ-004 Parameter ARRAY_SIZE, default 9, number of channels (one per systolic-array row).
REQ-005 Parameter AF_THRESH, default 248, almost-full occupancy threshold.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 clear  input  1  asynchronous, active-high reset.
REQ-008 w_en  input  ARRAY_SIZE  per-channel write request.
REQ-009 dataIn  input  ARRAY_SIZE*DATA_SIZE  packed write data; channel i at [i*DATA_SIZE +: DATA_SIZE].
REQ-010 r_en  input  1  common read request for all channels.
REQ-011 skew_en  input  1  selects diagonal-skewed output mode.
REQ-012 dataOut  output  ARRAY_SIZE*DATA_SIZE  packed read data, same packing as dataIn.
REQ-013 valid  output  ARRAY_SIZE  per-channel dataOut qualifier.
REQ-014 full, empty, almost_full  output  ARRAY_SIZE each  per-channel status flags.
REQ-015 count  output  ARRAY_SIZE*(LOG_DEPTH+1)  per-channel occupancy, packed as dataIn.

Function
REQ-016 A write on channel i SHALL be accepted iff w_en[i]=1 and full[i]=0; w_en[i] while full[i]=1 SHALL be dropped with no state change.
REQ-017 On r_en=1, every channel with empty[i]=0 SHALL pop one word; channels with empty[i]=1 SHALL ignore the read.
REQ-018 Read latency: with skew_en=0, the popped word SHALL appear on dataOut[i] with valid[i]=1 exactly one cycle after the r_en edge.
REQ-019 With skew_en=1, channel i output SHALL be delayed by a further i cycles (channel 0 at 1, channel ARRAY_SIZE-1 at ARRAY_SIZE cycles).
REQ-020 dataOut[i] SHALL be 0 whenever valid[i]=0 (zero padding for the array).
REQ-021 count[i] SHALL be +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither occur.
REQ-022 Simultaneous accepted read and write on a non-empty, non-full channel SHALL both complete; flags unchanged.
REQ-023 A write to an empty channel SHALL NOT be readable in the same cycle; empty[i] deasserts the cycle after the write.
REQ-024 full[i]=1 iff count[i]=FIFO_DEPTH; empty[i]=1 iff count[i]=0; almost_full[i]=1 iff count[i]>=AF_THRESH; all flags registered.
REQ-025 Read/write pointers SHALL be LOG_DEPTH bits and wrap from FIFO_DEPTH-1 to 0 without data loss.
REQ-026 Skew delay lines SHALL shift every cycle regardless of skew_en; a skew_en change SHALL take effect on the next cycle's output mux, in-flight words of the deselected path being discarded.

Reset
REQ-027 clear=1 SHALL asynchronously force pointers and count to 0, empty to all-ones, full/almost_full/valid to 0, dataOut to 0, skew delay lines to 0.
REQ-028 Storage contents SHALL NOT be reset; clear asserted mid-operation SHALL discard all queued and in-flight words.
REQ-029 The first accepted write SHALL be possible on the first rising edge after clear deasserts.

Structure
REQ-030 Shared package cnn_pkg SHALL hold DATA_SIZE and ARRAY_SIZE defaults and the channel-slice width constants.
REQ-031 One sub-module fifo_channel (single-clock FIFO with count and flags) SHALL be instantiated ARRAY_SIZE times by generate; skew logic and output muxing SHALL live in fifo_bank.

Verification
REQ-032 Reset, write 0x01 on ch0 only, r_en next cycle, skew_en=0 -> dataOut[0]=0x01, valid=9'b000000001 one cycle after r_en; empty[0] back to 1.
REQ-033 Write 256 words 0x00..0xFF to ch3, then 257th write 0x55 -> full[3]=1 after 256th, almost_full[3]=1 from 248th, 0x55 dropped, count[3]=256.
REQ-034 Fill all channels with 0x10+i, skew_en=1, one r_en -> valid[i] rises exactly i+1 cycles after r_en with dataOut[i]=0x10+i; other cycles dataOut=0.
REQ-035 Ch5 holding 10 words, simultaneous write and read for 300 cycles -> count[5] stays 10, order preserved across pointer wrap.
REQ-036 Clear asserted mid-stream with words in skew lines -> all outputs 0, empty all-ones within the same cycle, no stale valid after deassert.
